noc_switch_n: RTL and testbench

//  Parametrised N-port NoC switch: next generation of the 3-port top/bottom/right switch.
//  Per-input FIFO, destination-range routing and per-output round-robin arbiter.

---
 rtl/noc_switch_n.sv | 186 ++++++++++++++++++
 tb/tb_noc_switch_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_switch_n.sv
// noc_switch_n: N-port NoC switch with per-input FIFOs, destination-range routing and
// per-output round-robin arbitration. Define NOC_SWITCH_PKT_LOCK_EN for packet locking (i_last/o_last).
module noc_switch_n #(
  parameter int                       DATA_WIDTH   = 32,
  parameter int                       NUM_PORTS    = 3,
  parameter int                       FIFO_DEPTH   = 16,
  parameter int                       ADDR_MSB     = 31,
  parameter int                       ADDR_LSB     = 24,
  parameter logic [NUM_PORTS*8-1:0]   PORT_MIN     = {8'd0, 8'd2, 8'd0},
  parameter logic [NUM_PORTS*8-1:0]   PORT_MAX     = {8'd0, 8'd2, 8'd0},
  parameter int                       DEFAULT_PORT = NUM_PORTS - 1
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_PORTS-1:0]            i_data_valid,
  output logic [NUM_PORTS-1:0]            o_data_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_data,
  output logic [NUM_PORTS-1:0]            o_data_valid,
  input  logic [NUM_PORTS-1:0]            i_data_ready,
`ifdef NOC_SWITCH_PKT_LOCK_EN
  input  logic [NUM_PORTS-1:0]            i_last,
  output logic [NUM_PORTS-1:0]            o_last,
`endif
  output logic [NUM_PORTS-1:0]            o_dbg_busy
);

  // Handshake: a flit moves on a port in every cycle where valid and ready are both high at the
  // clock edge; valid never depends on ready, and once raised valid/data hold until that edge.

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef NOC_SWITCH_PKT_LOCK_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  logic [EW-1:0]        r_mem        [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr     [NUM_PORTS];
  logic [AW-1:0]        r_rd_ptr     [NUM_PORTS];
  logic [CW-1:0]        r_count      [NUM_PORTS];
  state_t               r_state      [NUM_PORTS];
  state_t               w_state_nxt  [NUM_PORTS];
  logic [PW-1:0]        r_grant      [NUM_PORTS];
  logic [PW-1:0]        w_grant_nxt  [NUM_PORTS];
  logic [PW-1:0]        r_last_grant [NUM_PORTS];
  logic [PW-1:0]        w_last_grant_nxt [NUM_PORTS];
  logic [PW-1:0]        w_cand       [NUM_PORTS];
  logic [EW-1:0]        w_head       [NUM_PORTS];
  logic [EW-1:0]        w_in_word    [NUM_PORTS];
  logic [7:0]           w_dest       [NUM_PORTS];
  logic [PW-1:0]        w_route      [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_push, w_pop, w_empty, w_locked, w_hit, w_found;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_empty[p]      = (r_count[p] == '0);
      o_data_ready[p] = (r_count[p] != CW'(FIFO_DEPTH));
      w_push[p]       = i_data_valid[p] & o_data_ready[p];
      w_head[p]       = r_mem[p][r_rd_ptr[p]];
`ifdef NOC_SWITCH_PKT_LOCK_EN
      w_in_word[p]    = {i_last[p], i_data[p*DATA_WIDTH +: DATA_WIDTH]};
`else
      w_in_word[p]    = i_data[p*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
  end

  // Lowest-numbered matching range wins; unmatched destinations fall to DEFAULT_PORT.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_dest[p]  = 8'(w_head[p][ADDR_MSB:ADDR_LSB]);
      w_route[p] = PW'(DEFAULT_PORT);
      w_hit[p]   = 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (!w_hit[p] && (w_dest[p] >= PORT_MIN[8*o +: 8]) && (w_dest[p] <= PORT_MAX[8*o +: 8])) begin
          w_route[p] = PW'(o);
          w_hit[p]   = 1'b1;
        end
      end
    end
  end

  // An input held by a busy output is invisible to every other arbiter (matters for body flits).
  always_comb begin
    w_locked = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (r_state[o] == S_BUSY) w_locked[r_grant[o]] = 1'b1;
    end
  end

  always_comb begin
    o_data       = '0;
    o_data_valid = '0;
    o_dbg_busy   = '0;
    w_pop        = '0;
    w_found      = '0;
`ifdef NOC_SWITCH_PKT_LOCK_EN
    o_last       = '0;
`endif
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_state_nxt[o]      = r_state[o];
      w_grant_nxt[o]      = r_grant[o];
      w_last_grant_nxt[o] = r_last_grant[o];
      w_cand[o]           = '0;
      case (r_state[o])
        S_IDLE: begin
          for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand[o] = rr_idx(r_last_grant[o], k);
            if (!w_found[o] && !w_empty[w_cand[o]] && !w_locked[w_cand[o]] &&
                (w_route[w_cand[o]] == PW'(o))) begin
              w_found[o]     = 1'b1;
              w_grant_nxt[o] = w_cand[o];
              w_state_nxt[o] = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          o_dbg_busy[o] = 1'b1;
          // The FIFO can run dry between body flits of a locked packet; valid drops meanwhile.
          if (!w_empty[r_grant[o]]) begin
            o_data_valid[o]                    = 1'b1;
            o_data[o*DATA_WIDTH +: DATA_WIDTH] = w_head[r_grant[o]][DATA_WIDTH-1:0];
`ifdef NOC_SWITCH_PKT_LOCK_EN
            o_last[o]                          = w_head[r_grant[o]][DATA_WIDTH];
`endif
            if (i_data_ready[o]) begin
              w_pop[r_grant[o]]   = 1'b1;
              w_last_grant_nxt[o] = r_grant[o];
`ifdef NOC_SWITCH_PKT_LOCK_EN
              if (w_head[r_grant[o]][DATA_WIDTH]) w_state_nxt[o] = S_IDLE;
`else
              w_state_nxt[o] = S_IDLE;
`endif
            end
          end
        end
        default: w_state_nxt[o] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wr_ptr[p]     <= '0;
        r_rd_ptr[p]     <= '0;
        r_count[p]      <= '0;
        r_state[p]      <= S_IDLE;
        r_grant[p]      <= '0;
        r_last_grant[p] <= PW'(NUM_PORTS - 1);
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_push[p]) r_wr_ptr[p] <= r_wr_ptr[p] + AW'(1);
        if (w_pop[p])  r_rd_ptr[p] <= r_rd_ptr[p] + AW'(1);
        case ({w_push[p], w_pop[p]})
          2'b10:   r_count[p] <= r_count[p] + CW'(1);
          2'b01:   r_count[p] <= r_count[p] - CW'(1);
          default: r_count[p] <= r_count[p];
        endcase
        r_state[p]      <= w_state_nxt[p];
        r_grant[p]      <= w_grant_nxt[p];
        r_last_grant[p] <= w_last_grant_nxt[p];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_push[p]) r_mem[p][r_wr_ptr[p]] <= w_in_word[p];
    end
  end

endmodule

// File: tb/tb_noc_switch_n.sv
// Directed testbench for noc_switch_n: reset, routing, round-robin, backpressure, wrap and
// (with NOC_SWITCH_PKT_LOCK_EN) packet locking, checked against a scoreboard of expected flits.
module tb_noc_switch_n;
  localparam int DW = 32;
  localparam int NP = 3;
  localparam int W  = 35;  // {last, out_port[1:0], data[31:0]}

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*DW-1:0]  i_data = '0;
  logic [NP-1:0]     i_data_valid = '0;
  logic [NP-1:0]     o_data_ready;
  logic [NP*DW-1:0]  o_data;
  logic [NP-1:0]     o_data_valid;
  logic [NP-1:0]     i_data_ready = '1;
  logic [NP-1:0]     i_last = '1;
  logic [NP-1:0]     o_last;
  logic [NP-1:0]     dbg_busy;

  logic [W-1:0]      exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                hs_cnt[NP];
  logic              rand_rdy = 1'b0;
  logic              saw_full = 1'b0;

  noc_switch_n dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
`ifdef NOC_SWITCH_PKT_LOCK_EN
    .i_last       (i_last),
    .o_last       (o_last),
`endif
    .o_dbg_busy   (dbg_busy)
  );

`ifndef NOC_SWITCH_PKT_LOCK_EN
  assign o_last = '1;
`endif

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected summary)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) i_data_ready[2] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    i_data       = '0;
    i_data_valid = '0;
    i_data_ready = '1;
    i_last       = '1;
    rand_rdy     = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_flit(input int p, input logic [31:0] d, input logic lst,
                           input logic add_exp, input logic [1:0] ep);
    int t;
    t = 0;
    i_data[p*DW +: DW] = d;
    i_data_valid[p]    = 1'b1;
    i_last[p]          = lst;
    @(negedge clk);
    while (!o_data_ready[p] && t < 200) begin
      saw_full = 1'b1;
      tick();
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("push_accept", 32'(o_data_ready[p]), 1);
    else if (add_exp) exp_q.push_back({lst, ep, d});
    tick();
    i_data_valid[p] = 1'b0;
    i_last[p]       = 1'b1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    check("drain", 32'(exp_q.size()), 0);
    repeat (3) tick();
  endtask

  // scoreboard / monitor
  logic [NP-1:0] prev_stall = '0;
  logic [NP-1:0] mid_pkt = '0;
  logic [DW-1:0] prev_data[NP];
  logic [DW-1:0] mon_d;
  logic [W-1:0]  mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = '0;
      mid_pkt    = '0;
      for (int p = 0; p < NP; p++) hs_cnt[p] = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        mon_d = o_data[p*DW +: DW];
        if (prev_stall[p]) begin
          check("hold_valid", 32'(o_data_valid[p]), 1);
          check("hold_data", mon_d, prev_data[p]);
        end
        if (mid_pkt[p]) check("pkt_consec", 32'(o_data_valid[p] & i_data_ready[p]), 1);
        if (!o_data_valid[p]) check("idle_zero", mon_d, 0);
        if (o_data_valid[p] && i_data_ready[p]) begin
          hs_cnt[p]++;
          check("q_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("out_port", p, 32'(mon_e[33:32]));
            check("out_data", mon_d, mon_e[31:0]);
`ifdef NOC_SWITCH_PKT_LOCK_EN
            check("out_last", 32'(o_last[p]), 32'(mon_e[34]));
`endif
          end
        end
        prev_stall[p] = o_data_valid[p] & ~i_data_ready[p];
        prev_data[p]  = mon_d;
`ifdef NOC_SWITCH_PKT_LOCK_EN
        mid_pkt[p]    = o_data_valid[p] & i_data_ready[p] & ~o_last[p];
`endif
      end
    end
  end

  initial begin
    // reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_ready", 32'(o_data_ready), 32'h7);
    check("rst_valid", 32'(o_data_valid), 0);
    check("rst_data_lo", o_data[31:0], 0);
    check("rst_busy", 32'(dbg_busy), 0);
    tick();

    // T1: reset in the middle of a stalled transfer
    do_reset();
    i_data_ready[1] = 1'b0;
    push_flit(0, 32'h0200_1111, 1'b1, 1'b0, 2'd1);
    push_flit(0, 32'h0200_2222, 1'b1, 1'b0, 2'd1);
    repeat (3) tick();
    @(negedge clk);
    check("t1_pre_valid", 32'(o_data_valid[1]), 1);
    check("t1_pre_data", o_data[63:32], 32'h0200_1111);
    tick();
    rst_n = 1'b0;
    #1;
    check("t1_valid_now", 32'(o_data_valid), 0);
    check("t1_ready_now", 32'(o_data_ready), 32'h7);
    check("t1_data_now", o_data[63:32], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    i_data_ready = '1;
    repeat (10) tick();
    @(negedge clk);
    check("t1_no_emerge", hs_cnt[1], 0);
    check("t1_valid_after", 32'(o_data_valid), 0);
    tick();

    // T2: routing and first-flit latency
    do_reset();
    push_flit(0, 32'h00AA_0001, 1'b1, 1'b1, 2'd0);
    @(negedge clk);
    check("t2_lat1", 32'(o_data_valid[0]), 0);
    tick();
    @(negedge clk);
    check("t2_lat2", 32'(o_data_valid[0]), 1);
    tick();
    push_flit(0, 32'h02AA_0002, 1'b1, 1'b1, 2'd1);
    push_flit(0, 32'h05AA_0003, 1'b1, 1'b1, 2'd2);
    wait_drain();
    check("t2_cnt0", hs_cnt[0], 1);
    check("t2_cnt1", hs_cnt[1], 1);
    check("t2_cnt2", hs_cnt[2], 1);

    // T3: round-robin among three inputs competing for output 1
    do_reset();
    i_data_ready[1] = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 4; r++)
        push_flit(p, 32'h0200_0000 | (32'(p) << 8) | 32'(r), 1'b1, 1'b0, 2'd1);
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 3; p++)
        exp_q.push_back({1'b1, 2'd1, 32'h0200_0000 | (32'(p) << 8) | 32'(r)});
    i_data_ready[1] = 1'b1;
    wait_drain();
    check("t3_cnt", hs_cnt[1], 12);

    // T4: backpressure fills the FIFO, then 16+1 flits drain in order
    do_reset();
    i_data_ready[1] = 1'b0;
    for (int i = 0; i < 16; i++) push_flit(0, 32'h0200_0000 + 32'(i), 1'b1, 1'b1, 2'd1);
    @(negedge clk);
    check("t4_full", 32'(o_data_ready[0]), 0);
    tick();
    i_data[31:0]    = 32'h0200_0010;
    i_data_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t4_ready_low", 32'(o_data_ready[0]), 0);
      check("t4_stall_data", o_data[63:32], 32'h0200_0000);
      tick();
    end
    i_data_ready[1] = 1'b1;
    push_flit(0, 32'h0200_0010, 1'b1, 1'b1, 2'd1);
    wait_drain();
    check("t4_cnt", hs_cnt[1], 17);

    // T5: 40 flits across pointer wrap with random downstream ready
    do_reset();
    saw_full = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++)
      push_flit(1, 32'h0500_0000 + 32'(i) * 32'h0001_0203, 1'b1, 1'b1, 2'd2);
    rand_rdy        = 1'b0;
    i_data_ready[2] = 1'b1;
    wait_drain();
    check("t5_saw_full", 32'(saw_full), 1);
    check("t5_cnt", hs_cnt[2], 40);

`ifdef NOC_SWITCH_PKT_LOCK_EN
    // T6: two 4-flit packets to output 1 must not interleave
    do_reset();
    i_data_ready[1] = 1'b0;
    for (int k = 0; k < 4; k++) push_flit(0, 32'h0200_A000 + 32'(k), 1'(k == 3), 1'b0, 2'd1);
    for (int k = 0; k < 4; k++) push_flit(2, 32'h0200_C000 + 32'(k), 1'(k == 3), 1'b0, 2'd1);
    for (int k = 0; k < 4; k++) exp_q.push_back({1'(k == 3), 2'd1, 32'h0200_A000 + 32'(k)});
    for (int k = 0; k < 4; k++) exp_q.push_back({1'(k == 3), 2'd1, 32'h0200_C000 + 32'(k)});
    i_data_ready[1] = 1'b1;
    wait_drain();
    check("t6_cnt", hs_cnt[1], 8);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
